// File: rtl/csr_regfile_if.sv
// csr_regfile_if: bus between the MEM stage and the machine-mode CSR stage.
//   master (pipeline side): drives csrin_*, observes csrout_*
//   slave  (csr_regfile)  : observes csrin_*, drives csrout_*
// Signals:
//   csrin_valid, csrin_inst[31:0], csrin_pc[31:0], csrin_rs1_data[31:0],
//   csrin_csr_write, csrin_mem_is_mret
//   csrout_rdata[31:0], csrout_redirect, csrout_redirect_pc[31:0],
//   csrout_flush, csrout_busy
interface csr_regfile_if;
    logic        csrin_valid;
    logic [31:0] csrin_inst;
    logic [31:0] csrin_pc;
    logic [31:0] csrin_rs1_data;
    logic        csrin_csr_write;
    logic        csrin_mem_is_mret;

    logic [31:0] csrout_rdata;
    logic        csrout_redirect;
    logic [31:0] csrout_redirect_pc;
    logic        csrout_flush;
    logic        csrout_busy;

    modport master (
        output csrin_valid, csrin_inst, csrin_pc, csrin_rs1_data,
               csrin_csr_write, csrin_mem_is_mret,
        input  csrout_rdata, csrout_redirect, csrout_redirect_pc,
               csrout_flush, csrout_busy
    );

    modport slave (
        input  csrin_valid, csrin_inst, csrin_pc, csrin_rs1_data,
               csrin_csr_write, csrin_mem_is_mret,
        output csrout_rdata, csrout_redirect, csrout_redirect_pc,
               csrout_flush, csrout_busy
    );
endinterface

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR storage and update stage.
//   Holds mtvec (0x305), mepc (0x341) and mstatus (0x300). Executes
//   CSRRW/S/C and their immediate forms, takes traps on ecall/unimp and
//   returns on mret. A trap or mret redirects fetch and holds a flush to the
//   younger stages for FLUSH_CYCLES cycles, during which all inputs are ignored.
// Ports:
//   clk   - rising-edge clock
//   rstn  - asynchronous active-low reset
//   csr   - csr_regfile_if.slave (csrin_* requests, csrout_* results)
// Parameters:
//   RESET_MTVEC  - mtvec after reset (bits [1:0] forced to 0)
//   FLUSH_CYCLES - flush length after trap/mret, 1..15
// Configuration macro:
//   CSR_MCAUSE_EN - adds a 32-bit mcause at 0x342, written by traps
//                   (11 for ecall, 2 for unimp). Undefined: 0x342 is unknown.
//
// FSM states:
//   state | meaning
//   IDLE  | accepting instructions
//   FLUSH | trap/mret in progress; flush held, inputs ignored
module csr_regfile #(
    parameter logic [31:0] RESET_MTVEC  = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic         clk,
    input logic         rstn,
    csr_regfile_if.slave csr
);

    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_UNIMP = 32'hc000_1073;
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [3:0]  FLUSH_LOAD   = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {IDLE, FLUSH} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        flush_q;
    logic        busy_q;
    logic        redirect_q;
    logic [31:0] redirect_pc_q;

    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mstatus_mie;
    logic        mstatus_mpie;
`ifdef CSR_MCAUSE_EN
    logic [31:0] mcause;
`endif

    logic [31:0] inst;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_field;
    logic        accept;
    logic        is_trap_inst;
    logic        trap_fire;
    logic        mret_fire;
    logic        addr_known;
    logic        csr_fire;
    logic        csr_wr;
    logic [31:0] old_val;
    logic [31:0] src;
    logic [31:0] new_val;
    logic [31:0] mstatus_rd;

    assign inst      = csr.csrin_inst;
    assign funct3    = inst[14:12];
    assign csr_addr  = inst[31:20];
    assign rs1_field = inst[19:15];

    assign accept       = csr.csrin_valid & ~busy_q;
    assign is_trap_inst = (inst == INST_ECALL) || (inst == INST_UNIMP);
    assign trap_fire    = accept & csr.csrin_csr_write & is_trap_inst;
    assign mret_fire    = accept & csr.csrin_mem_is_mret & ~trap_fire;

    // MPP reads as machine mode; only MIE and MPIE are backed by flops.
    assign mstatus_rd = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};

    always_comb begin
        old_val    = 32'd0;
        addr_known = 1'b0;
        case (csr_addr)
            ADDR_MSTATUS: begin old_val = mstatus_rd; addr_known = 1'b1; end
            ADDR_MTVEC:   begin old_val = mtvec;      addr_known = 1'b1; end
            ADDR_MEPC:    begin old_val = mepc;       addr_known = 1'b1; end
`ifdef CSR_MCAUSE_EN
            ADDR_MCAUSE:  begin old_val = mcause;     addr_known = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign csr_fire = accept & csr.csrin_csr_write & (funct3 != 3'd0) & addr_known
                    & ~trap_fire & ~mret_fire;

    assign src = funct3[2] ? {27'd0, rs1_field} : csr.csrin_rs1_data;

    always_comb begin
        new_val = old_val;
        csr_wr  = 1'b0;
        case (funct3[1:0])
            2'b01: begin new_val = src;            csr_wr = 1'b1; end
            2'b10: begin new_val = old_val | src;  csr_wr = (rs1_field != 5'd0); end
            2'b11: begin new_val = old_val & ~src; csr_wr = (rs1_field != 5'd0); end
            default: ;
        endcase
        csr_wr = csr_wr & csr_fire;
    end

    // CSR storage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mtvec        <= RESET_MTVEC & 32'hFFFF_FFFC;
            mepc         <= 32'd0;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
`ifdef CSR_MCAUSE_EN
            mcause       <= 32'd0;
`endif
        end else if (trap_fire) begin
            mepc         <= csr.csrin_pc & 32'hFFFF_FFFC;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
`ifdef CSR_MCAUSE_EN
            mcause       <= (inst == INST_ECALL) ? 32'd11 : 32'd2;
`endif
        end else if (mret_fire) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (csr_wr) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mstatus_mie  <= new_val[3];
                    mstatus_mpie <= new_val[7];
                end
                ADDR_MTVEC: mtvec <= new_val & 32'hFFFF_FFFC;
                ADDR_MEPC:  mepc  <= new_val & 32'hFFFF_FFFC;
`ifdef CSR_MCAUSE_EN
                ADDR_MCAUSE: mcause <= new_val;
`endif
                default: ;
            endcase
        end
    end

    // Redirect/flush sequencer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    redirect_q <= 1'b0;
                    if (trap_fire || mret_fire) begin
                        state         <= FLUSH;
                        cnt           <= FLUSH_LOAD;
                        flush_q       <= 1'b1;
                        busy_q        <= 1'b1;
                        redirect_q    <= 1'b1;
                        // mtvec sampled before any same-edge update
                        redirect_pc_q <= trap_fire ? mtvec : mepc;
                    end
                end
                FLUSH: begin
                    redirect_q <= 1'b0;
                    if (cnt == 4'd0) begin
                        state   <= IDLE;
                        flush_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign csr.csrout_rdata       = old_val;
    assign csr.csrout_redirect    = redirect_q;
    assign csr.csrout_redirect_pc = redirect_pc_q;
    assign csr.csrout_flush       = flush_q;
    assign csr.csrout_busy        = busy_q;

endmodule

// File: tb/tb_csr_regfile.sv
module tb_csr_regfile;

    localparam logic [31:0] RST_MTVEC = 32'h0000_0043;
    localparam int          FC        = 2;
    localparam logic [31:0] ECALL     = 32'h0000_0073;
    localparam logic [31:0] UNIMP     = 32'hc000_1073;
    localparam logic [31:0] MRET      = 32'h3020_0073;

    logic clk;
    logic rstn;
    int   tests;
    int   fails;

    csr_regfile_if bus ();

    csr_regfile #(.RESET_MTVEC(RST_MTVEC), .FLUSH_CYCLES(FC)) dut (
        .clk  (clk),
        .rstn (rstn),
        .csr  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [11:0] a, input logic [4:0] rs,
                                        input logic [2:0] f3);
        return {a, rs, f3, 5'd1, 7'h73};
    endfunction

    // Present one instruction for one cycle; rd is the combinational rdata seen
    // before the edge. Returns at the negedge after the accepting edge.
    task automatic op(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic cw, input logic mr,
                      output logic [31:0] rd);
        @(negedge clk);
        bus.csrin_valid       = v;
        bus.csrin_inst        = inst;
        bus.csrin_pc          = pc;
        bus.csrin_rs1_data    = rs1;
        bus.csrin_csr_write   = cw;
        bus.csrin_mem_is_mret = mr;
        #1 rd = bus.csrout_rdata;
        @(negedge clk);
        bus.csrin_valid       = 1'b0;
        bus.csrin_inst        = 32'd0;
        bus.csrin_csr_write   = 1'b0;
        bus.csrin_mem_is_mret = 1'b0;
    endtask

    task automatic read_csr(input logic [11:0] a, output logic [31:0] val);
        bus.csrin_valid = 1'b0;
        bus.csrin_inst  = enc(a, 5'd0, 3'd2);
        #1 val = bus.csrout_rdata;
        bus.csrin_inst  = 32'd0;
    endtask

    // Counts flush-high cycles and redirect pulses from the current negedge on.
    task automatic count_flush(output int nf, output int nr);
        nf = 0;
        nr = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.csrout_redirect) nr++;
            if (!bus.csrout_flush) break;
            nf++;
            @(negedge clk);
        end
        if (bus.csrout_flush) begin
            tests++; fails++;
            $display("FAIL flush_timeout: flush still high after 20 cycles");
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rstn = 1'b0;
        bus.csrin_valid = 0; bus.csrin_inst = 0; bus.csrin_pc = 0;
        bus.csrin_rs1_data = 0; bus.csrin_csr_write = 0; bus.csrin_mem_is_mret = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        tests++; if (bus.csrout_flush !== 1'b0) begin fails++; $display("FAIL rst_flush: got %b expected 0", bus.csrout_flush); end
        tests++; if (bus.csrout_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", bus.csrout_busy); end
        tests++; if (bus.csrout_redirect !== 1'b0) begin fails++; $display("FAIL rst_redirect: got %b expected 0", bus.csrout_redirect); end
        tests++; if (bus.csrout_redirect_pc !== 32'd0) begin fails++; $display("FAIL rst_redirect_pc: got %h expected 0", bus.csrout_redirect_pc); end
        read_csr(12'h305, v);
        tests++; if (v !== 32'h0000_0040) begin fails++; $display("FAIL rst_mtvec: got %h expected 00000040", v); end
        read_csr(12'h341, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL rst_mepc: got %h expected 0", v); end
        read_csr(12'h300, v);
        tests++; if (v !== 32'h0000_1800) begin fails++; $display("FAIL rst_mstatus: got %h expected 00001800", v); end
    endtask

    task automatic test_csrrw;
        logic [31:0] rd, v;
        op(1, enc(12'h305, 5'd2, 3'd1), 32'h100, 32'h8000_0103, 1, 0, rd);
        tests++; if (rd !== 32'h0000_0040) begin fails++; $display("FAIL csrrw_rdata: got %h expected 00000040", rd); end
        read_csr(12'h305, v);
        tests++; if (v !== 32'h8000_0100) begin fails++; $display("FAIL csrrw_mtvec: got %h expected 80000100", v); end
        tests++; if (bus.csrout_flush !== 1'b0 || bus.csrout_busy !== 1'b0 || bus.csrout_redirect !== 1'b0) begin
            fails++; $display("FAIL csrrw_noflush: got f%b b%b r%b expected all 0",
                              bus.csrout_flush, bus.csrout_busy, bus.csrout_redirect);
        end
    endtask

    task automatic test_trap;
        logic [31:0] rd, v;
        int nf, nr;
        op(1, enc(12'h305, 5'd3, 3'd1), 0, 32'h0000_0100, 1, 0, rd);
        tests++; if (rd !== 32'h8000_0100) begin fails++; $display("FAIL trap_set_mtvec: got %h expected 80000100", rd); end
        op(1, enc(12'h300, 5'd8, 3'd6), 0, 0, 1, 0, rd);
        read_csr(12'h300, v);
        tests++; if (v !== 32'h0000_1808) begin fails++; $display("FAIL trap_set_mie: got %h expected 00001808", v); end
        op(1, ECALL, 32'h2004, 0, 1, 0, rd);
        tests++; if (bus.csrout_redirect !== 1'b1) begin fails++; $display("FAIL trap_redirect: got %b expected 1", bus.csrout_redirect); end
        tests++; if (bus.csrout_redirect_pc !== 32'h100) begin fails++; $display("FAIL trap_redirect_pc: got %h expected 00000100", bus.csrout_redirect_pc); end
        tests++; if (bus.csrout_busy !== 1'b1) begin fails++; $display("FAIL trap_busy: got %b expected 1", bus.csrout_busy); end
        read_csr(12'h341, v);
        tests++; if (v !== 32'h2004) begin fails++; $display("FAIL trap_mepc: got %h expected 00002004", v); end
        read_csr(12'h300, v);
        tests++; if (v !== 32'h0000_1880) begin fails++; $display("FAIL trap_mstatus: got %h expected 00001880", v); end
`ifdef CSR_MCAUSE_EN
        read_csr(12'h342, v);
        tests++; if (v !== 32'd11) begin fails++; $display("FAIL trap_mcause: got %h expected 0000000b", v); end
`endif
        count_flush(nf, nr);
        tests++; if (nf != FC) begin fails++; $display("FAIL trap_flush_len: got %0d expected %0d", nf, FC); end
        tests++; if (nr != 1) begin fails++; $display("FAIL trap_redirect_cnt: got %0d expected 1", nr); end
    endtask

    task automatic test_mret;
        logic [31:0] rd, v;
        int nf, nr;
        op(1, enc(12'h341, 5'd4, 3'd1), 0, 32'h0000_200B, 1, 0, rd);
        tests++; if (rd !== 32'h2004) begin fails++; $display("FAIL mret_old_mepc: got %h expected 00002004", rd); end
        read_csr(12'h341, v);
        tests++; if (v !== 32'h2008) begin fails++; $display("FAIL mret_mepc_mask: got %h expected 00002008", v); end
        op(1, MRET, 32'h3000, 0, 0, 1, rd);
        tests++; if (bus.csrout_redirect !== 1'b1) begin fails++; $display("FAIL mret_redirect: got %b expected 1", bus.csrout_redirect); end
        tests++; if (bus.csrout_redirect_pc !== 32'h2008) begin fails++; $display("FAIL mret_redirect_pc: got %h expected 00002008", bus.csrout_redirect_pc); end
        read_csr(12'h300, v);
        tests++; if (v !== 32'h0000_1888) begin fails++; $display("FAIL mret_mstatus: got %h expected 00001888", v); end
        count_flush(nf, nr);
        tests++; if (nf != FC) begin fails++; $display("FAIL mret_flush_len: got %0d expected %0d", nf, FC); end
    endtask

    task automatic test_flush_ignore;
        logic [31:0] rd, v;
        int nf, nr;
        op(1, ECALL, 32'h3000, 0, 1, 0, rd);
        bus.csrin_valid     = 1'b1;
        bus.csrin_inst      = ECALL;
        bus.csrin_pc        = 32'h4000;
        bus.csrin_csr_write = 1'b1;
        count_flush(nf, nr);
        bus.csrin_valid     = 1'b0;
        bus.csrin_inst      = 32'd0;
        bus.csrin_csr_write = 1'b0;
        tests++; if (nr != 1) begin fails++; $display("FAIL ignore_redirect_cnt: got %0d expected 1", nr); end
        tests++; if (nf != FC) begin fails++; $display("FAIL ignore_flush_len: got %0d expected %0d", nf, FC); end
        read_csr(12'h341, v);
        tests++; if (v !== 32'h3000) begin fails++; $display("FAIL ignore_mepc: got %h expected 00003000", v); end
        read_csr(12'h300, v);
        tests++; if (v !== 32'h0000_1880) begin fails++; $display("FAIL ignore_mstatus: got %h expected 00001880", v); end
    endtask

    task automatic test_csrrs_rc;
        logic [31:0] rd, v;
        op(1, enc(12'h300, 5'd0, 3'd2), 0, 32'hFFFF_FFFF, 1, 0, rd);
        tests++; if (rd !== 32'h0000_1880) begin fails++; $display("FAIL rs_x0_rdata: got %h expected 00001880", rd); end
        read_csr(12'h300, v);
        tests++; if (v !== 32'h0000_1880) begin fails++; $display("FAIL rs_x0_nowrite: got %h expected 00001880", v); end
        op(1, enc(12'h300, 5'd5, 3'd1), 0, 32'hFFFF_FFFF, 1, 0, rd);
        read_csr(12'h300, v);
        tests++; if (v !== 32'h0000_1888) begin fails++; $display("FAIL rw_mstatus_mask: got %h expected 00001888", v); end
        op(1, enc(12'h300, 5'd8, 3'd7), 0, 0, 1, 0, rd);
        tests++; if (rd !== 32'h0000_1888) begin fails++; $display("FAIL rci_rdata: got %h expected 00001888", rd); end
        read_csr(12'h300, v);
        tests++; if (v !== 32'h0000_1880) begin fails++; $display("FAIL rci_mie_clear: got %h expected 00001880", v); end
        op(1, enc(12'h300, 5'd0, 3'd3), 0, 32'hFFFF_FFFF, 1, 0, rd);
        read_csr(12'h300, v);
        tests++; if (v !== 32'h0000_1880) begin fails++; $display("FAIL rc_x0_nowrite: got %h expected 00001880", v); end
        // csr_write deasserted: no update even for a valid csr op
        op(1, enc(12'h305, 5'd6, 3'd1), 0, 32'h0000_0ABC, 0, 0, rd);
        read_csr(12'h305, v);
        tests++; if (v !== 32'h100) begin fails++; $display("FAIL no_csr_write: got %h expected 00000100", v); end
    endtask

    task automatic test_unimp_valid;
        logic [31:0] rd, v;
        int nf, nr;
        op(0, ECALL, 32'h5000, 0, 1, 0, rd);
        tests++; if (bus.csrout_redirect !== 1'b0 || bus.csrout_flush !== 1'b0) begin
            fails++; $display("FAIL invalid_ecall: got r%b f%b expected 0 0", bus.csrout_redirect, bus.csrout_flush);
        end
        read_csr(12'h341, v);
        tests++; if (v !== 32'h3000) begin fails++; $display("FAIL invalid_mepc: got %h expected 00003000", v); end
        op(1, UNIMP, 32'h6006, 32'hFFFF_FFFF, 1, 0, rd);
        tests++; if (bus.csrout_redirect_pc !== 32'h100) begin fails++; $display("FAIL unimp_redirect_pc: got %h expected 00000100", bus.csrout_redirect_pc); end
        read_csr(12'h341, v);
        tests++; if (v !== 32'h6004) begin fails++; $display("FAIL unimp_mepc: got %h expected 00006004", v); end
`ifdef CSR_MCAUSE_EN
        read_csr(12'h342, v);
        tests++; if (v !== 32'd2) begin fails++; $display("FAIL unimp_mcause: got %h expected 00000002", v); end
`endif
        count_flush(nf, nr);
        tests++; if (nf != FC) begin fails++; $display("FAIL unimp_flush_len: got %0d expected %0d", nf, FC); end
    endtask

    task automatic test_unknown_addr;
        logic [31:0] rd, v;
        op(1, enc(12'h342, 5'd7, 3'd1), 0, 32'h0000_0055, 1, 0, rd);
        read_csr(12'h342, v);
`ifdef CSR_MCAUSE_EN
        tests++; if (rd !== 32'd2) begin fails++; $display("FAIL mcause_old: got %h expected 00000002", rd); end
        tests++; if (v !== 32'h55) begin fails++; $display("FAIL mcause_write: got %h expected 00000055", v); end
`else
        tests++; if (rd !== 32'd0) begin fails++; $display("FAIL unk342_rdata: got %h expected 0", rd); end
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL unk342_read: got %h expected 0", v); end
`endif
        op(1, enc(12'h7C0, 5'd7, 3'd1), 0, 32'h1234_5678, 1, 0, rd);
        tests++; if (rd !== 32'd0) begin fails++; $display("FAIL unk7c0_rdata: got %h expected 0", rd); end
    endtask

    task automatic test_reset_mid_flush;
        logic [31:0] rd, v;
        op(1, ECALL, 32'h7000, 0, 1, 0, rd);
        tests++; if (bus.csrout_flush !== 1'b1) begin fails++; $display("FAIL midrst_pre_flush: got %b expected 1", bus.csrout_flush); end
        rstn = 1'b0;
        #1;
        tests++; if (bus.csrout_flush !== 1'b0 || bus.csrout_busy !== 1'b0 || bus.csrout_redirect !== 1'b0) begin
            fails++; $display("FAIL midrst_async: got f%b b%b r%b expected all 0",
                              bus.csrout_flush, bus.csrout_busy, bus.csrout_redirect);
        end
        read_csr(12'h305, v);
        tests++; if (v !== 32'h40) begin fails++; $display("FAIL midrst_mtvec: got %h expected 00000040", v); end
        @(negedge clk);
        rstn = 1'b1;
        op(1, enc(12'h305, 5'd1, 3'd1), 0, 32'h0000_0200, 1, 0, rd);
        read_csr(12'h305, v);
        tests++; if (v !== 32'h200) begin fails++; $display("FAIL midrst_after: got %h expected 00000200", v); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset;
        test_csrrw;
        test_trap;
        test_mret;
        test_flush_ignore;
        test_csrrs_rc;
        test_unimp_valid;
        test_unknown_addr;
        test_reset_mid_flush;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
